// File: rtl/cache_pkg.sv
// Shared cache geometry constants and the memory responder state encoding.
package cache_pkg;
  localparam int LINE_SIZE_BYTES = 64;
  localparam int OFFSET_BITS     = 6;
  localparam int DATA_WIDTH      = 32;
  localparam int ADDRESS_WIDTH   = 32;
  localparam int BEATS           = LINE_SIZE_BYTES * 8 / DATA_WIDTH;
  localparam int BEAT_BITS       = $clog2(BEATS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_READ,
    ST_WRITE
  } rsp_state_e;
endpackage

// File: rtl/mem_line_store.sv
// Word-addressed backing store: one synchronous write port, one combinational read port, no reset.
module mem_line_store #(
  parameter int DEPTH = 16384,
  parameter int AW    = 14,
  parameter int W     = 32
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);
  logic [W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/mem_line_responder.sv
// Memory-side responder: returns line fills as beat bursts and absorbs writeback bursts.
module mem_line_responder
  import cache_pkg::*;
#(
  parameter int MEM_LINES    = 1024,
  parameter int READ_LATENCY = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  output logic                     wr_done,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_WIDTH-1:0]    rsp_data,
  output logic                     rsp_last
);
  localparam int LIDX_W = $clog2(MEM_LINES);
  localparam int LAT_W  = (READ_LATENCY > 0) ? $clog2(READ_LATENCY + 1) : 1;
  localparam int WA_W   = LIDX_W + BEAT_BITS;

  rsp_state_e             r_state;
  logic [LIDX_W-1:0]      r_line;
  logic [BEAT_BITS-1:0]   r_beat;
  logic [LAT_W-1:0]       r_lat;
  logic                   r_wr_done;
  logic                   w_we;
  logic                   w_last_beat;
  logic [DATA_WIDTH-1:0]  w_rd_data;
  logic                   w_unused;

  assign w_unused    = ^req_addr;
  assign w_we        = (r_state == ST_WRITE) && wr_valid;
  assign w_last_beat = (r_beat == BEAT_BITS'(BEATS - 1));

  // Line index and beat concatenate directly into the word address.
  mem_line_store #(
    .DEPTH (MEM_LINES * BEATS),
    .AW    (WA_W),
    .W     (DATA_WIDTH)
  ) u_store (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr ({r_line, r_beat}),
    .i_wdata (wr_data),
    .i_raddr ({r_line, r_beat}),
    .o_rdata (w_rd_data)
  );

  assign req_ready = (r_state == ST_IDLE) && !rst;
  assign wr_ready  = (r_state == ST_WRITE);
  assign rsp_valid = (r_state == ST_READ);
  assign rsp_last  = (r_state == ST_READ) && w_last_beat;
  assign rsp_data  = (r_state == ST_READ) ? w_rd_data : '0;
  assign wr_done   = r_wr_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_line    <= '0;
      r_beat    <= '0;
      r_lat     <= '0;
      r_wr_done <= 1'b0;
    end else begin
      r_wr_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_line <= req_addr[OFFSET_BITS +: LIDX_W];
            r_beat <= '0;
            if (req_write) begin
              r_state <= ST_WRITE;
            end else if (READ_LATENCY == 0) begin
              r_state <= ST_READ;
            end else begin
              r_state <= ST_WAIT;
              r_lat   <= LAT_W'(READ_LATENCY);
            end
          end
        end
        ST_WAIT: begin
          r_lat <= r_lat - LAT_W'(1);
          if (r_lat == LAT_W'(1)) r_state <= ST_READ;
        end
        ST_READ: begin
          if (rsp_ready) begin
            r_beat <= r_beat + BEAT_BITS'(1);
            if (w_last_beat) r_state <= ST_IDLE;
          end
        end
        ST_WRITE: begin
          if (wr_valid) begin
            r_beat <= r_beat + BEAT_BITS'(1);
            if (w_last_beat) begin
              r_state   <= ST_IDLE;
              r_wr_done <= 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_line_responder.sv
// Directed bench for mem_line_responder: writeback/fill, latency, backpressure, aliasing, busy, reset abort.
module tb_mem_line_responder;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr;
  logic        wr_valid, wr_ready, wr_done;
  logic [31:0] wr_data;
  logic        rsp_valid, rsp_ready, rsp_last;
  logic [31:0] rsp_data;

  logic        z_req_valid, z_req_ready, z_wr_ready, z_wr_done;
  logic        z_rsp_valid, z_rsp_ready, z_rsp_last;
  logic [31:0] z_rsp_data;

  int errors = 0;
  int checks = 0;

  logic [31:0] fd [16];
  logic        fl [16];
  int          f_hs, f_lat, f_bad, f_st;
  logic        f_after;
  logic [31:0] f_sd;
  int          w_bad;

  always #5 clk = ~clk;

  mem_line_responder #(.MEM_LINES(1024), .READ_LATENCY(4)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .wr_data(wr_data), .wr_done(wr_done),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_last(rsp_last)
  );

  mem_line_responder #(.MEM_LINES(16), .READ_LATENCY(0)) u_dut0 (
    .clk(clk), .rst(rst), .req_valid(z_req_valid), .req_ready(z_req_ready),
    .req_write(1'b0), .req_addr(32'h0000_0040), .wr_valid(1'b0),
    .wr_ready(z_wr_ready), .wr_data(32'h0), .wr_done(z_wr_done),
    .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready), .rsp_data(z_rsp_data),
    .rsp_last(z_rsp_last)
  );

  // Writeback of n beats (base+i), with gap_n idle cycles inserted before beat gap_beat.
  task automatic write_line(input logic [31:0] addr, input logic [31:0] base,
                            input int n, input int gap_beat, input int gap_n);
    int i, g, guard;
    w_bad = 0;
    @(negedge clk);
    if (req_ready !== 1'b1) w_bad++;
    req_valid = 1'b1; req_write = 1'b1; req_addr = addr;
    @(posedge clk);
    i = 0; g = 0; guard = 0;
    while (i < n && guard < 100) begin
      @(negedge clk);
      req_valid = 1'b0; req_write = 1'b0;
      if (i == gap_beat && g < gap_n) begin
        wr_valid = 1'b0; wr_data = 32'hDEAD_BEEF; g++;
      end else begin
        wr_valid = 1'b1; wr_data = base + i;
        if (wr_ready !== 1'b1) w_bad++;
        i++;
      end
      @(posedge clk);
      guard++;
    end
    if (guard >= 100) w_bad++;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  // Fill request; records beats, first-beat latency and handshakes; stalls stall_n cycles on stall_beat.
  task automatic fill(input logic [31:0] addr, input int stall_beat, input int stall_n);
    int n;
    f_hs = 0; f_lat = 0; f_bad = 0; f_st = 0; f_sd = '0;
    @(negedge clk);
    if (req_ready !== 1'b1) f_bad++;
    req_valid = 1'b1; req_write = 1'b0; req_addr = addr; rsp_ready = 1'b1;
    @(posedge clk);
    n = 0;
    while (f_hs < 16 && n < 200) begin
      @(negedge clk);
      req_valid = 1'b0; n++;
      if (rsp_valid === 1'b1) begin
        if (f_lat == 0) f_lat = n;
        if (f_hs == stall_beat && f_st < stall_n) begin
          if (f_st == 0) f_sd = rsp_data;
          else if (rsp_data !== f_sd || rsp_last !== 1'b0) f_bad++;
          rsp_ready = 1'b0; f_st++;
        end else begin
          if (f_st > 0 && f_hs == stall_beat && rsp_data !== f_sd) f_bad++;
          rsp_ready = 1'b1; fd[f_hs] = rsp_data; fl[f_hs] = rsp_last; f_hs++;
        end
      end else if (f_lat != 0) f_bad++;
      @(posedge clk);
    end
    @(negedge clk);
    f_after = rsp_valid; rsp_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    checks++;
    if ({rsp_valid, rsp_last, wr_ready, wr_done} !== 4'b0 || rsp_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b l=%b wr=%b wd=%b d=%h, want all 0",
               rsp_valid, rsp_last, wr_ready, wr_done, rsp_data);
    end
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || z_req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_req_ready: got %b/%b want 1/1", req_ready, z_req_ready);
    end
  endtask

  task automatic test_writeback();
    write_line(32'h0000_0040, 32'h1000, 16, -1, 0);
    checks++;
    if (w_bad != 0) begin errors++; $display("FAIL wb_accept: got %0d stalls want 0", w_bad); end
    checks++;
    if (wr_done !== 1'b1 || req_ready !== 1'b1) begin
      errors++; $display("FAIL wb_done_pulse: got done=%b ready=%b want 1/1", wr_done, req_ready);
    end
    @(negedge clk);
    checks++;
    if (wr_done !== 1'b0) begin errors++; $display("FAIL wb_done_width: got %b want 0", wr_done); end
  endtask

  task automatic test_fill();
    int bad_d, bad_l;
    fill(32'h0000_0040, -1, 0);
    bad_d = 0; bad_l = 0;
    for (int i = 0; i < 16; i++) begin
      if (fd[i] !== 32'h1000 + i) bad_d++;
      if (fl[i] !== (i == 15)) bad_l++;
    end
    checks++;
    if (bad_d != 0) begin errors++; $display("FAIL fill_data: got %0d bad beats (b0=%h) want 0", bad_d, fd[0]); end
    checks++;
    if (bad_l != 0) begin errors++; $display("FAIL fill_last: got %0d bad flags want 0", bad_l); end
    checks++;
    if (f_lat != 5) begin errors++; $display("FAIL fill_latency: got T+%0d want T+5", f_lat); end
    checks++;
    if (f_bad != 0 || f_after !== 1'b0) begin
      errors++; $display("FAIL fill_end: got bad=%0d after=%b want 0/0", f_bad, f_after);
    end
  endtask

  task automatic test_latency0();
    int n, beats;
    logic last_ok;
    @(negedge clk);
    checks++;
    if (z_rsp_valid !== 1'b0) begin errors++; $display("FAIL lat0_idle: got %b want 0", z_rsp_valid); end
    z_req_valid = 1'b1; z_rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    z_req_valid = 1'b0;
    checks++;
    if (z_rsp_valid !== 1'b1) begin errors++; $display("FAIL lat0_first: got %b want 1 at T+1", z_rsp_valid); end
    beats = 0; n = 0; last_ok = 1'b1;
    while (beats < 16 && n < 40) begin
      if (z_rsp_valid === 1'b1) begin
        if (z_rsp_last !== (beats == 15)) last_ok = 1'b0;
        beats++;
      end
      @(negedge clk); n++;
    end
    checks++;
    if (beats != 16 || !last_ok || z_rsp_valid !== 1'b0) begin
      errors++; $display("FAIL lat0_burst: got beats=%0d last_ok=%b v=%b want 16/1/0", beats, last_ok, z_rsp_valid);
    end
  endtask

  task automatic test_backpressure();
    fill(32'h0000_0040, 7, 3);
    checks++;
    if (f_st != 3 || f_sd !== 32'h1007) begin
      errors++; $display("FAIL stall_hold: got cycles=%0d data=%h want 3/1007", f_st, f_sd);
    end
    checks++;
    if (f_hs != 16 || fd[7] !== 32'h1007 || fd[8] !== 32'h1008 || !fl[15] || f_bad != 0) begin
      errors++; $display("FAIL stall_burst: got hs=%0d b7=%h b8=%h bad=%0d want 16/1007/1008/0",
                         f_hs, fd[7], fd[8], f_bad);
    end
  endtask

  task automatic test_write_gap();
    int bad;
    write_line(32'h0000_00C0, 32'h5000, 16, 8, 2);
    checks++;
    if (w_bad != 0 || wr_done !== 1'b1) begin
      errors++; $display("FAIL gap_wb: got stalls=%0d done=%b want 0/1", w_bad, wr_done);
    end
    fill(32'h0000_00C0, -1, 0);
    bad = 0;
    for (int i = 0; i < 16; i++) if (fd[i] !== 32'h5000 + i) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL gap_data: got %0d bad beats (b8=%h) want 0", bad, fd[8]); end
  endtask

  task automatic test_alias_offset();
    int bad;
    fill(32'h0000_0040 + 1024 * 64, -1, 0);
    bad = 0;
    for (int i = 0; i < 16; i++) if (fd[i] !== 32'h1000 + i) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL alias_data: got %0d bad beats (b0=%h) want 0", bad, fd[0]); end
    fill(32'h0000_007C, -1, 0);
    checks++;
    if (fd[0] !== 32'h1000 || fd[15] !== 32'h100F) begin
      errors++; $display("FAIL offset_order: got b0=%h b15=%h want 1000/100F", fd[0], fd[15]);
    end
  endtask

  task automatic test_busy();
    int n, beats, busy_bad;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_0040; rsp_ready = 1'b1;
    @(posedge clk);
    beats = 0; n = 0; busy_bad = 0;
    while (beats < 16 && n < 100) begin
      @(negedge clk); n++;
      if (req_ready !== 1'b0) busy_bad++;
      if (rsp_valid === 1'b1) beats++;
      @(posedge clk);
    end
    @(negedge clk);
    checks++;
    if (busy_bad != 0 || beats != 16) begin
      errors++; $display("FAIL busy_reject: got ready_hi=%0d beats=%0d want 0/16", busy_bad, beats);
    end
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL busy_first_idle: got ready=%b v=%b want 1/0", req_ready, rsp_valid);
    end
    @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if (req_ready !== 1'b0) begin errors++; $display("FAIL busy_accepted: got ready=%b want 0", req_ready); end
    beats = 0; n = 0;
    while (beats < 16 && n < 100) begin
      if (rsp_valid === 1'b1) beats++;
      @(negedge clk); n++;
    end
    checks++;
    if (beats != 16 || req_ready !== 1'b1) begin
      errors++; $display("FAIL busy_second_fill: got beats=%0d ready=%b want 16/1", beats, req_ready);
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    write_line(32'h0000_0080, 32'h2000, 16, -1, 0);
    @(negedge clk);
    write_line(32'h0000_0080, 32'h3000, 6, -1, 0);
    rst = 1'b1;
    #1;
    checks++;
    if ({wr_ready, wr_done, rsp_valid, rsp_last} !== 4'b0 || rsp_data !== 32'h0) begin
      errors++; $display("FAIL rst_mid_outputs: got wr=%b wd=%b v=%b l=%b want 0", wr_ready, wr_done, rsp_valid, rsp_last);
    end
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    checks++;
    if (wr_done !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL rst_mid_idle: got done=%b ready=%b want 0/1", wr_done, req_ready);
    end
    fill(32'h0000_0080, -1, 0);
    bad = 0;
    for (int i = 0; i < 16; i++) if (fd[i] !== ((i < 6) ? 32'h3000 + i : 32'h2000 + i)) bad++;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL rst_mid_data: got %0d bad beats (b5=%h b6=%h) want 0", bad, fd[5], fd[6]);
    end
  endtask

  initial begin
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    wr_valid = 1'b0; wr_data = '0; rsp_ready = 1'b1;
    z_req_valid = 1'b0; z_rsp_ready = 1'b1;
    test_reset();
    test_writeback();
    test_fill();
    test_latency0();
    test_backpressure();
    test_write_gap();
    test_alias_offset();
    test_busy();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_line_responder.md
Name: mem_line_responder

Overview:
- Memory-side responder for the 4-way set-associative cache controller.
- Services line-fill requests by returning a full cache line as a burst of DATA_WIDTH beats.
- Accepts dirty-line writebacks as a burst of beats into an internal backing store.
- Sits below the cache controller as the target of its fetch/writeback traffic; also serves as the bench memory model for cache verification.

Parameters:
- LINE_SIZE_BYTES, 64, bytes per cache line.
- DATA_WIDTH, 32, bits per beat.
- ADDRESS_WIDTH, 32, request address width.
- OFFSET_BITS, 6, log2(LINE_SIZE_BYTES); address offset bits, ignored by this block.
- MEM_LINES, 1024, backing store depth in lines; must be a power of 2.
- READ_LATENCY, 4, idle cycles between request acceptance and the first read beat; 0 is allowed.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request (high only in IDLE).
- req_write  in  1  1 = writeback, 0 = line fill; sampled at request handshake.
- req_addr  in  ADDRESS_WIDTH  line address; offset bits ignored.
- wr_valid  in  1  writeback beat present.
- wr_ready  out  1  writeback beat accepted this cycle.
- wr_data  in  DATA_WIDTH  writeback beat data.
- wr_done  out  1  one-cycle pulse after the last writeback beat is stored.
- rsp_valid  out  1  fill beat valid.
- rsp_ready  in  1  controller accepts fill beat.
- rsp_data  out  DATA_WIDTH  fill beat data.
- rsp_last  out  1  marks the final beat of a fill.

Behaviour:
- Derived values:
  - BEATS = LINE_SIZE_BYTES*8/DATA_WIDTH (16 at defaults).
  - LINE_IDX = req_addr[OFFSET_BITS +: log2(MEM_LINES)]; upper bits are dropped, so line addresses alias modulo MEM_LINES.
  - Word address = LINE_IDX*BEATS + beat.
- Storage:
  - MEM_LINES*BEATS words of DATA_WIDTH.
  - Not reset; contents are undefined until written.
- Reset (async, rst=1):
  - State goes to IDLE; beat and latency counters clear to 0.
  - rsp_valid=0, rsp_last=0, rsp_data=0, wr_ready=0, wr_done=0.
  - req_ready=1 from the first cycle after rst deasserts.
- FSM states: IDLE, WAIT, READ, WRITE.
- IDLE:
  - req_ready=1.
  - On req_valid && req_ready: latch LINE_IDX and req_write; clear beat to 0.
  - If req_write=1, go to WRITE.
  - Else if READ_LATENCY=0, go to READ.
  - Else go to WAIT with latency counter = READ_LATENCY.
- WAIT:
  - Latency counter decrements each cycle; at 1, go to READ.
  - Timing: if the handshake is in cycle T, the first rsp_valid is in cycle T+1+READ_LATENCY.
- READ:
  - rsp_valid=1; rsp_data = mem[word address], read combinationally from the registered beat pointer.
  - rsp_last = (beat == BEATS-1).
  - While rsp_ready=0, rsp_data and rsp_last hold stable.
  - Each rsp_valid && rsp_ready advances beat by 1.
  - The handshake on the last beat goes to IDLE; rsp_valid drops the next cycle.
- WRITE:
  - wr_ready=1.
  - Each wr_valid && wr_ready writes wr_data to mem[word address] on that edge, then beat advances.
  - Gaps where wr_valid=0 are allowed.
  - After the last beat is written, go to IDLE; wr_done=1 for exactly the next cycle, coincident with req_ready=1.
- Request ordering:
  - Requests are never queued; req_valid outside IDLE is not accepted (req_ready=0).
  - A fill accepted in the wr_done cycle returns the freshly written data.
- Beat order: always beat 0 first; no critical-word-first.
- Beat counter: log2(BEATS) bits; wraps to 0 after BEATS-1.
- Reset mid-burst:
  - Aborts the burst and returns to IDLE.
  - Beats already written stay in storage.
  - No rsp_last or wr_done is emitted for the aborted burst.

Decomposition:
- Shared package cache_pkg holds:
  - LINE_SIZE_BYTES, OFFSET_BITS, DATA_WIDTH, ADDRESS_WIDTH;
  - the BEATS constant;
  - the responder state enum (IDLE, WAIT, READ, WRITE).
- One sub-module, mem_line_store:
  - MEM_LINES*BEATS word array;
  - one synchronous write port and one combinational read port;
  - no reset.
- FSM and counters stay in mem_line_responder.

Test Plan:
- Writeback then fill: write line addr 0x0000_0040 with beats 0x1000+i (i=0..15) -> wr_done pulses once the cycle after beat 15. Then fill the same addr -> rsp_data 0x1000..0x100F in order, rsp_last only on beat 15.
- Latency: READ_LATENCY=4, fill handshake at cycle T -> first rsp_valid at T+5. With READ_LATENCY=0 -> first rsp_valid at T+1.
- Backpressure:
  - Hold rsp_ready=0 for 3 cycles on beat 7 -> rsp_data stays 0x1007 and rsp_valid stays 1; the burst completes with 16 handshakes total.
  - Drop wr_valid for 2 cycles mid-writeback -> no extra writes occur.
- Aliasing and offset:
  - Fill addr 0x0000_0040 + MEM_LINES*64 -> returns the same data as addr 0x40.
  - Fill addr 0x0000_007C -> also returns beat 0 first.
- Busy rejection: assert req_valid during a READ burst -> req_ready=0 and the request is accepted only in the first IDLE cycle.
- Reset mid-burst: assert rst after writeback beat 5 -> outputs go to reset values immediately. A later fill returns new data on beats 0..5 and the old contents on beats 6..15.
